rgb2ycbcr_cfg: RTL and testbench
================================

// Module: rgb2ycbcr_cfg
// PURPOSE
//  Parametrised RGB->YCbCr 4:4:4 converter for the video processing chain.
//  - Configurable input channel widths (RGB565 up to RGB888).
//  - Per-frame selectable BT.601 or BT.709 coefficients, full or limited range.
//  - Rounding and saturation on every output.
//  - Sits between the capture/DDR read path and the Y-based processors; sync signals are delayed in step with the data.
// PARAMETERS
//  IN_R_W  5  red input width, 4..8
//  IN_G_W  6  green input width, 4..8
//  IN_B_W  5  blue input width, 4..8
// PORTS
//  clk               in   1       module clock
//  rst               in   1       synchronous reset, active-high
//  std_sel           in   1       0=BT.601, 1=BT.709 (sampled at frame start)
//  range_sel         in   1       0=full 0..255, 1=limited Y16..235 / C16..240 (sampled at frame start)
//  pre_frame_vsync   in   1       input vsync
//  pre_frame_hsync   in   1       input hsync
//  pre_frame_de      in   1       input data enable
//  img_red           in   IN_R_W  red
//  img_green         in   IN_G_W  green
//  img_blue          in   IN_B_W  blue
//  post_frame_vsync  out  1       vsync delayed 4 clk
//  post_frame_hsync  out  1       hsync delayed 4 clk
//  post_frame_de     out  1       de delayed 4 clk
//  img_y             out  8       luma
//  img_cb            out  8       blue-difference chroma
//  img_cr            out  8       red-difference chroma
//  cfg_active        out  2       {range, std} currently applied
// BEHAVIOUR
//  Reset:
//  - All outputs, pipeline registers and sync delay lines clear to 0.
//  - cfg_active = 2'b00 (BT.601 full).
//  - Reset mid-frame flushes the pipe; outputs stay 0 until new input has propagated 4 clk.
//  Input expansion:
//  - Each channel is bit-replicated to 8 bits: {x, x[W-1 -: 8-W]}.
//  - A width of 8 passes straight through.
//  Config latch:
//  - Rising edge of pre_frame_vsync (vsync=1 and previous-cycle vsync=0) loads std_sel/range_sel into cfg_active in that same cycle.
//  - That vsync-rise pixel and every later pixel use the new set.
//  - Mid-frame changes on std_sel/range_sel are ignored until the next vsync rise.
//  Pipeline, latency exactly 4 clk, one pixel per clk, no stalls:
//  - S1: expand and register RGB; capture coefficient set from cfg_active.
//  - S2: nine products, 8b unsigned x 8b coefficient.
//  - S3: signed 18b sum + (offset<<8) + 128 (round half up).
//  - S4: arithmetic >>8, then clamp; limited range clamps Y 16..235, C 16..240; full range clamps 0..255.
//  - The sync delay line is 4 deep, bit-aligned with data.
//  - img_y/cb/cr are forced to 0 whenever post_frame_de=0.
//  Coefficients, Q8, as (R,G,B) +offset:
//    601 full: Y 77,150,29 +0;  Cb -43,-85,128 +128; Cr 128,-107,-21 +128
//    709 full: Y 54,183,19 +0;  Cb -29,-99,128 +128; Cr 128,-116,-12 +128
//    601 lim:  Y 66,129,25 +16; Cb -38,-74,112 +128; Cr 112,-94,-18 +128
//    709 lim:  Y 47,157,16 +16; Cb -26,-87,112 +128; Cr 112,-102,-10 +128
//  Simultaneous vsync rise and de=1: the pixel uses the newly latched set.
// TESTING
//  1. RGB565 white 1F/3F/1F, 601 full, de=1 -> 4 clk later Y=255, Cb=128, Cr=128.
//  2. Same pixel, limited range latched at vsync rise -> Y=235, Cb=128, Cr=128.
//  3. Black, limited range -> Y=16, Cb=128, Cr=128.
//  4. Pure red 1F/00/00 -> 601 full Y=77, Cb=85, Cr=255 (saturated); 709 full Y=54, Cr=255.
//  5. Toggle std_sel mid-line with vsync low -> cfg_active and outputs unchanged until the next vsync rise.
//  6. Pulse rst with de high mid-line -> all outputs 0 next clk; a single de pulse reappears exactly 4 clk after re-driving.

Source files
------------

// File: rtl/rgb2ycbcr_cfg.sv
// rgb2ycbcr_cfg: RGB->YCbCr 4:4:4 converter with a selectable BT.601/709 standard and full/limited range,
// latched at each frame start; 4-clk pipeline with the sync signals delayed alongside the data.
module rgb2ycbcr_cfg #(
    parameter int IN_R_W = 5,
    parameter int IN_G_W = 6,
    parameter int IN_B_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              std_sel,
    input  logic              range_sel,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_de,
    input  logic [IN_R_W-1:0] img_red,
    input  logic [IN_G_W-1:0] img_green,
    input  logic [IN_B_W-1:0] img_blue,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_de,
    output logic [7:0]        img_y,
    output logic [7:0]        img_cb,
    output logic [7:0]        img_cr,
    output logic [1:0]        cfg_active
);
    // Rows indexed by {range, std}; columns Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
    localparam logic signed [8:0] K [4][9] = '{
        '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21},
        '{9'sd54, 9'sd183, 9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12},
        '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94,  -9'sd18},
        '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd87, 9'sd112, 9'sd112, -9'sd102, -9'sd10}
    };

    logic [7:0]        r8, g8, b8;
    logic              vs_prev;
    logic [1:0]        cfg_now;
    logic [3:0]        vs_d, hs_d, de_d;
    logic [7:0]        px1 [3];
    logic [1:0]        cfg1;
    logic signed [17:0] p2 [9];
    logic              rng2, rng3;
    logic signed [17:0] s3 [3];
    logic [7:0]        cl [3];

    if (IN_R_W == 8) begin : g_r8
        assign r8 = img_red;
    end else begin : g_rx
        assign r8 = {img_red, img_red[IN_R_W-1 -: 8-IN_R_W]};
    end
    if (IN_G_W == 8) begin : g_g8
        assign g8 = img_green;
    end else begin : g_gx
        assign g8 = {img_green, img_green[IN_G_W-1 -: 8-IN_G_W]};
    end
    if (IN_B_W == 8) begin : g_b8
        assign b8 = img_blue;
    end else begin : g_bx
        assign b8 = {img_blue, img_blue[IN_B_W-1 -: 8-IN_B_W]};
    end

    // The vsync-rise pixel itself already uses the newly selected set
    assign cfg_now = (pre_frame_vsync && !vs_prev) ? {range_sel, std_sel} : cfg_active;

    for (genvar c = 0; c < 3; c++) begin : g_clamp
        logic signed [9:0] v, lo, hi;
        assign v     = s3[c][17:8];
        assign lo    = rng3 ? 10'sd16 : 10'sd0;
        assign hi    = !rng3 ? 10'sd255 : (c == 0) ? 10'sd235 : 10'sd240;
        assign cl[c] = (v < lo) ? lo[7:0] : (v > hi) ? hi[7:0] : v[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev    <= 1'b0;
            cfg_active <= 2'b00;
            vs_d       <= '0;
            hs_d       <= '0;
            de_d       <= '0;
            px1        <= '{default: '0};
            cfg1       <= 2'b00;
            p2         <= '{default: '0};
            rng2       <= 1'b0;
            rng3       <= 1'b0;
            s3         <= '{default: '0};
            img_y      <= '0;
            img_cb     <= '0;
            img_cr     <= '0;
        end else begin
            vs_prev    <= pre_frame_vsync;
            cfg_active <= cfg_now;
            vs_d       <= {vs_d[2:0], pre_frame_vsync};
            hs_d       <= {hs_d[2:0], pre_frame_hsync};
            de_d       <= {de_d[2:0], pre_frame_de};
            px1        <= '{r8, g8, b8};
            cfg1       <= cfg_now;
            rng2       <= cfg1[1];
            rng3       <= rng2;
            for (int j = 0; j < 9; j++)
                p2[j] <= $signed({1'b0, px1[j % 3]}) * K[cfg1][j];
            for (int j = 0; j < 3; j++)
                s3[j] <= p2[3*j] + p2[3*j+1] + p2[3*j+2] + 18'sd128
                         + ((j != 0) ? 18'sd32768 : rng2 ? 18'sd4096 : 18'sd0);
            img_y      <= de_d[2] ? cl[0] : 8'd0;
            img_cb     <= de_d[2] ? cl[1] : 8'd0;
            img_cr     <= de_d[2] ? cl[2] : 8'd0;
        end
    end

    assign post_frame_vsync = vs_d[3];
    assign post_frame_hsync = hs_d[3];
    assign post_frame_de    = de_d[3];
endmodule

// File: tb/tb_rgb2ycbcr_cfg.sv
// tb_rgb2ycbcr_cfg: directed stimulus for rgb2ycbcr_cfg, checked against an arithmetic reference model
// on every cycle plus hand-computed literal expectations.
module tb_rgb2ycbcr_cfg;
    logic       clk = 0, rst = 1, std_sel = 0, range_sel = 0;
    logic       vs = 0, hs = 0, de = 0;
    logic [4:0] r = 0;
    logic [5:0] g = 0;
    logic [4:0] b = 0;
    logic       o_vs, o_hs, o_de;
    logic [7:0] y, cb, cr;
    logic [1:0] cfg;
    int         npass = 0, ntot = 0;

    rgb2ycbcr_cfg dut (
        .clk(clk), .rst(rst), .std_sel(std_sel), .range_sel(range_sel),
        .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
        .img_red(r), .img_green(g), .img_blue(b),
        .post_frame_vsync(o_vs), .post_frame_hsync(o_hs), .post_frame_de(o_de),
        .img_y(y), .img_cb(cb), .img_cr(cr), .cfg_active(cfg)
    );

    always #5 clk = ~clk;

    // [cfg = {range,std}][channel Y/Cb/Cr] = {kR, kG, kB, offset}
    localparam int TAB [4][3][4] = '{
        '{'{77, 150, 29, 0},  '{-43, -85, 128, 128}, '{128, -107, -21, 128}},
        '{'{54, 183, 19, 0},  '{-29, -99, 128, 128}, '{128, -116, -12, 128}},
        '{'{66, 129, 25, 16}, '{-38, -74, 112, 128}, '{112, -94, -18, 128}},
        '{'{47, 157, 16, 16}, '{-26, -87, 112, 128}, '{112, -102, -10, 128}}
    };

    typedef struct packed {
        logic       vs, hs, de;
        logic [7:0] y, cb, cr;
    } out_t;

    out_t       exp_q [4];
    logic [1:0] m_cfg = 0;
    logic       m_vprev = 0;

    function automatic int ex(int x, int w);
        return (w == 8) ? x : ((x << (8 - w)) | (x >> (2 * w - 8)));
    endfunction

    function automatic logic [7:0] conv(int r8, int g8, int b8, logic [1:0] c, int ch);
        int acc, v, lo, hi;
        acc = TAB[c][ch][0] * r8 + TAB[c][ch][1] * g8 + TAB[c][ch][2] * b8 + TAB[c][ch][3] * 256 + 128;
        v   = acc >>> 8;
        lo  = c[1] ? 16 : 0;
        hi  = !c[1] ? 255 : (ch == 0) ? 235 : 240;
        v   = (v < lo) ? lo : (v > hi) ? hi : v;
        return 8'(v);
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        ntot++;
        if (got == want) npass++;
        else $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    endtask

    always @(posedge clk) begin
        out_t nx;
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i] = '0;
            m_cfg   = 0;
            m_vprev = 0;
        end else begin
            if (vs && !m_vprev) m_cfg = {range_sel, std_sel};
            m_vprev = vs;
            nx.vs = vs;
            nx.hs = hs;
            nx.de = de;
            nx.y  = de ? conv(ex(r, 5), ex(g, 6), ex(b, 5), m_cfg, 0) : 8'd0;
            nx.cb = de ? conv(ex(r, 5), ex(g, 6), ex(b, 5), m_cfg, 1) : 8'd0;
            nx.cr = de ? conv(ex(r, 5), ex(g, 6), ex(b, 5), m_cfg, 2) : 8'd0;
            for (int i = 3; i > 0; i--) exp_q[i] = exp_q[i-1];
            exp_q[0] = nx;
        end
    end

    always @(negedge clk) begin
        chk("m_vsync", o_vs, exp_q[3].vs);
        chk("m_hsync", o_hs, exp_q[3].hs);
        chk("m_de",    o_de, exp_q[3].de);
        chk("m_y",     y,    exp_q[3].y);
        chk("m_cb",    cb,   exp_q[3].cb);
        chk("m_cr",    cr,   exp_q[3].cr);
        chk("m_cfg",   cfg,  m_cfg);
    end

    // Presents one pixel for one clock, then idles and checks the result 4 clk after it was applied
    task automatic shot(input logic v, input logic [4:0] ri, input logic [5:0] gi, input logic [4:0] bi,
                        input int ey, input int ecb, input int ecr, input string nm);
        @(negedge clk);
        vs = v; de = 1; r = ri; g = gi; b = bi;
        @(negedge clk);
        vs = 0; de = 0; r = 0; g = 0; b = 0;
        repeat (3) @(negedge clk);
        chk({nm, "_y"}, y, ey);
        chk({nm, "_cb"}, cb, ecb);
        chk({nm, "_cr"}, cr, ecr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_y", y, 0);
        chk("rst_de", o_de, 0);
        chk("rst_cfg", cfg, 0);
        rst = 0;
        shot(0, 5'h1F, 6'h3F, 5'h1F, 255, 128, 128, "white_601f");
        range_sel = 1;
        shot(1, 5'h1F, 6'h3F, 5'h1F, 235, 128, 128, "white_601l");
        chk("cfg_lim", cfg, 2);
        shot(0, 5'h00, 6'h00, 5'h00, 16, 128, 128, "black_601l");
        range_sel = 0;
        shot(1, 5'h1F, 6'h00, 5'h00, 77, 85, 255, "red_601f");
        std_sel = 1;
        shot(1, 5'h1F, 6'h00, 5'h00, 54, 99, 255, "red_709f");
        std_sel = 0;
        shot(0, 5'h1F, 6'h00, 5'h00, 54, 99, 255, "red_midline");
        chk("cfg_hold", cfg, 1);
        @(negedge clk);
        de = 1; r = 5'h1F; g = 6'h3F; b = 5'h1F;
        repeat (5) @(negedge clk);
        chk("pre_rst_de", o_de, 1);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_de", o_de, 0);
        chk("rst_mid_cfg", cfg, 0);
        rst = 0; de = 0;
        @(negedge clk);
        de = 1; r = 5'h1F; g = 6'h00; b = 5'h00;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            de = 0;
            chk($sformatf("pulse_de_%0d", k), o_de, (k == 4) ? 1 : 0);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vs        = (i % 10 == 0);
            hs        = (i % 5 == 1);
            de        = (i % 10 != 9);
            std_sel   = ((i / 3) % 2) == 1;
            range_sel = ((i / 7) % 2) == 1;
            r         = 5'(i * 7);
            g         = 6'(i * 13);
            b         = 5'(31 - i);
        end
        @(negedge clk);
        vs = 0; hs = 0; de = 0;
        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
